// File: rtl/border_pkg.sv
// Shared constants and types for the frame assembler and border-detection stages.
// Latency: none, declarations only.
// Backpressure: not applicable.
package border_pkg;

  localparam int WIDTH  = 9;
  localparam int HEIGHT = 9;
  localparam int SIZE   = WIDTH * HEIGHT;
  localparam int IDX_W  = $clog2(SIZE);

  // Edge threshold used by the downstream border-detection stage.
  localparam logic [7:0] THRESH = 8'd64;

  typedef logic [7:0]       pixel_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(SIZE - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } asm_state_t;

endpackage

// File: rtl/frame_bank.sv
// One SIZE-byte frame store: single write port, whole array visible as output.
// Latency: a write at edge N is visible on mem from cycle N+1.
// Backpressure: none; the owner gates writes through we.
module frame_bank
  import border_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   we,
  input  idx_t   waddr,
  input  pixel_t wdata,
  output pixel_t mem [0:SIZE-1]
);

  // Storage: cleared on reset, one byte written per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr <= LAST_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/frame_assembler.sv
// Collects a raster pixel stream into ping-pong frame banks and presents a full frame.
// Latency: last pixel accepted at edge N gives frame_valid and frame_out from cycle N+1.
// Backpressure: pix_ready drops only while a completed frame waits for the held one to be acked.
module frame_assembler
  import border_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   pix_valid,
  input  pixel_t pix_data,
  input  logic   pix_sof,
  output logic   pix_ready,
  output pixel_t frame_out [0:SIZE-1],
  output logic   frame_valid,
  input  logic   frame_ack,
  output logic   sync_err
);

  asm_state_t state, state_nxt;
  idx_t       wr_idx, wr_idx_nxt;
  logic       wr_bank, wr_bank_nxt;
  logic       frame_valid_nxt;
  logic       sync_err_nxt;
  logic       wr_en;
  idx_t       wr_addr;
  logic       acc;
  logic       rd_free;
  logic       at_last;

  pixel_t bank0_q [0:SIZE-1];
  pixel_t bank1_q [0:SIZE-1];

  assign pix_ready = (state != WAIT);
  assign acc       = pix_valid && pix_ready;
  // The held frame can be replaced if nobody holds it or it is being taken this cycle.
  assign rd_free   = !frame_valid || frame_ack;
  assign at_last   = (wr_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, write control and handoff decisions.
  always_comb begin
    state_nxt       = state;
    wr_idx_nxt      = wr_idx;
    wr_bank_nxt     = wr_bank;
    frame_valid_nxt = frame_valid;
    sync_err_nxt    = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = wr_idx;

    // An ack retires the held frame; a swap below overrides this with the new frame.
    if (frame_ack) begin
      frame_valid_nxt = 1'b0;
    end

    case (state)
      HUNT: begin
        if (acc) begin
          if (pix_sof) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_idx_nxt = idx_t'(1);
            state_nxt  = FILL;
          end else begin
            sync_err_nxt = 1'b1;
          end
        end
      end

      FILL: begin
        if (acc) begin
          wr_en = 1'b1;
          if (pix_sof) begin
            // Early restart, including an sof landing on the last index.
            wr_addr      = '0;
            wr_idx_nxt   = idx_t'(1);
            sync_err_nxt = 1'b1;
          end else if (at_last) begin
            wr_idx_nxt = '0;
            if (rd_free) begin
              wr_bank_nxt     = ~wr_bank;
              frame_valid_nxt = 1'b1;
              state_nxt       = HUNT;
            end else begin
              state_nxt = WAIT;
            end
          end else begin
            wr_idx_nxt = wr_idx + idx_t'(1);
          end
        end
      end

      WAIT: begin
        // A completed frame sits in wr_bank; hand it over as soon as the held one is taken.
        if (frame_ack) begin
          wr_bank_nxt     = ~wr_bank;
          frame_valid_nxt = 1'b1;
          state_nxt       = HUNT;
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  // Datapath registers: fill index, bank select, output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      wr_idx      <= wr_idx_nxt;
      wr_bank     <= wr_bank_nxt;
      frame_valid <= frame_valid_nxt;
      sync_err    <= sync_err_nxt;
    end
  end

  frame_bank u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && !wr_bank),
    .waddr (wr_addr),
    .wdata (pix_data),
    .mem   (bank0_q)
  );

  frame_bank u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && wr_bank),
    .waddr (wr_addr),
    .wdata (pix_data),
    .mem   (bank1_q)
  );

  // Output mux: the bank not being written is the one presented.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      frame_out[i] = wr_bank ? bank0_q[i] : bank1_q[i];
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Self-checking bench for frame_assembler against a frame-level reference model.
// Latency: model outputs are compared on the falling edge after each rising edge.
// Backpressure: the bench holds an offered pixel until the model says it was taken.
module tb_frame_assembler;
  import border_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   pix_valid = 1'b0;
  pixel_t pix_data = '0;
  logic   pix_sof = 1'b0;
  logic   frame_ack = 1'b0;
  logic   pix_ready;
  logic   frame_valid;
  logic   sync_err;
  pixel_t frame_out [0:SIZE-1];

  always #5 clk = ~clk;

  frame_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .sync_err    (sync_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frames in progress, held and pending, as whole pixel lists.
  pixel_t m_part [$];
  pixel_t m_held [SIZE];
  pixel_t m_pend [SIZE];
  bit     m_hv;
  bit     m_pv;
  bit     m_err;
  bit     last_acc;
  string  fo_tag [SIZE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_part.delete();
    for (int k = 0; k < SIZE; k++) begin
      m_held[k] = '0;
      m_pend[k] = '0;
    end
    m_hv     = 1'b0;
    m_pv     = 1'b0;
    m_err    = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic check_all();
    chk("pix_ready", 32'(pix_ready), 32'(!m_pv));
    chk("frame_valid", 32'(frame_valid), 32'(m_hv));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    for (int k = 0; k < SIZE; k++) begin
      chk(fo_tag[k], 32'(frame_out[k]), 32'(m_held[k]));
    end
  endtask

  // One clock: apply the current inputs to the model, clock, then compare.
  task automatic step();
    bit acc;
    bit err;
    bit complete;
    acc      = pix_valid && !m_pv;
    err      = 1'b0;
    complete = 1'b0;
    if (acc) begin
      if (pix_sof) begin
        if (m_part.size() != 0) err = 1'b1;
        m_part.delete();
        m_part.push_back(pix_data);
      end else if (m_part.size() == 0) begin
        err = 1'b1;
      end else begin
        m_part.push_back(pix_data);
        if (m_part.size() == SIZE) complete = 1'b1;
      end
    end
    if (complete) begin
      if (!m_hv || frame_ack) begin
        for (int k = 0; k < SIZE; k++) m_held[k] = m_part[k];
        m_hv = 1'b1;
      end else begin
        for (int k = 0; k < SIZE; k++) m_pend[k] = m_part[k];
        m_pv = 1'b1;
      end
      m_part.delete();
    end else if (frame_ack && m_hv) begin
      if (m_pv) begin
        for (int k = 0; k < SIZE; k++) m_held[k] = m_pend[k];
        m_pv = 1'b0;
      end else begin
        m_hv = 1'b0;
      end
    end
    m_err    = err;
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input pixel_t dd, input bit ss, input bit aa = 1'b0);
    pix_valid = 1'b1;
    pix_data  = dd;
    pix_sof   = ss;
    frame_ack = aa;
    last_acc  = 1'b0;
    for (int n = 0; n < 300 && !last_acc; n++) step();
    chk("send_accepted", 32'(last_acc), 32'd1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    frame_ack = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack1();
    pix_valid = 1'b0;
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  task automatic send_frame(input pixel_t base, input int stride);
    for (int k = 0; k < SIZE; k++) send(pixel_t'(32'(base) + k * stride), k == 0);
  endtask

  task automatic async_reset();
    pix_valid = 1'b0;
    frame_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit     have;
    int     p;
    for (int k = 0; k < SIZE; k++) fo_tag[k] = $sformatf("frame_out[%0d]", k);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single frame 0..80, then held untouched, then acked away.
    send_frame(8'd0, 1);
    idle(3);
    ack1();
    idle(1);

    // Two frames back-to-back with no ack: second one waits, upstream is stalled.
    send_frame(8'd1, 1);
    send_frame(8'd100, 1);
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    pix_sof   = 1'b1;
    for (int i = 0; i < 3; i++) step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    ack1();
    idle(2);
    ack1();

    // Early restart: partial 0xFF frame abandoned by a new sof.
    send(8'hFF, 1'b1);
    for (int i = 0; i < 39; i++) send(8'hFF, 1'b0);
    send_frame(8'h10, 0);
    idle(2);
    ack1();

    // Missing sof: stray pixels are dropped with an error each.
    for (int i = 0; i < 5; i++) send(pixel_t'(i + 200), 1'b0);
    send_frame(8'd7, 3);
    idle(1);
    ack1();

    // Ack coincides with the last pixel of the following frame.
    send_frame(8'd50, 1);
    for (int k = 0; k < SIZE - 1; k++) send(pixel_t'(k * 2), k == 0);
    send(8'd222, 1'b0, 1'b1);
    idle(2);
    ack1();

    // Sof on the last index restarts instead of completing.
    for (int k = 0; k < SIZE - 1; k++) send(pixel_t'(k), k == 0);
    send(8'd9, 1'b1);
    idle(1);

    // Reset in the middle of a frame, with a frame already held.
    send_frame(8'd3, 2);
    for (int k = 0; k < 30; k++) send(pixel_t'(k + 60), k == 0);
    async_reset();
    idle(1);
    send_frame(8'd20, 1);
    idle(1);
    ack1();

    // Randomized traffic with occasional framing errors and random acks.
    have = 1'b0;
    p    = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!have) begin
        pix_data = pixel_t'($urandom);
        pix_sof  = (p == 0) ^ ($urandom_range(149) == 0);
        have     = 1'b1;
      end
      pix_valid = ($urandom_range(3) != 0);
      frame_ack = ($urandom_range(40) == 0);
      step();
      if (last_acc) begin
        have = 1'b0;
        p    = pix_sof ? 1 : (p + 1) % SIZE;
      end
    end
    pix_valid = 1'b0;
    frame_ack = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
